// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 definitions for the hex-dump panel.
//  - command bytes used during init and row addressing
//  - frame FSM state encoding
//  - row DDRAM base table, init-sequence table, nibble-to-ASCII helper
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_DDRAM    = 8'h80;  // OR with DDRAM address
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_ROW_ADDR,
    ST_CHARS,
    ST_FRAME_END,
    ST_IDLE
  } panel_state_t;

  // DDRAM start address of each display row.
  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] hex2ascii(input logic [3:0] h);
    return (h <= 4'd9) ? (8'h30 + {4'h0, h}) : (8'h37 + {4'h0, h});
  endfunction

endpackage

// File: rtl/lcd_hex_panel_if.sv
// lcd_hex_panel_if: HD44780 pin bundle.
//  LCD_DATA  8-bit data bus
//  LCD_RW    read/write select (always write here)
//  LCD_EN    enable strobe
//  LCD_RS    0 = command, 1 = character
//  master: the driver side; slave: the display / monitor side.
interface lcd_hex_panel_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (output LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
  modport slave  (input  LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
endinterface

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one HD44780 write per accepted byte.
//  iCLK, iRST     clock, synchronous active-high reset
//  i_start        request to write i_rs_data (taken when o_ready)
//  i_rs_data      {RS, DATA}
//  o_done         1 in the final cycle of a write
//  o_ready        idle, or finishing this cycle (back-to-back writes have no gap)
//  lcd            LCD pins
// A write occupies 2*SETUP_CYC + EN_CYC + WR_DLY cycles, counted from the
// accept edge: RS/DATA set up, EN high for EN_CYC, RS/DATA held, then WR_DLY.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYC    = 16,
  parameter int SETUP_CYC = 4,
  parameter int WR_DLY    = 262142
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       i_start,
  input  logic [8:0] i_rs_data,
  output logic       o_done,
  output logic       o_ready,
  lcd_hex_panel_if.master lcd
);

  localparam int TOTAL = 2*SETUP_CYC + EN_CYC + WR_DLY;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] EN_LO = CW'(SETUP_CYC);
  localparam logic [CW-1:0] EN_HI = CW'(SETUP_CYC + EN_CYC);

  logic          r_act;
  logic [CW-1:0] r_cnt;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          w_accept;
  logic [CW-1:0] w_cnt_inc;

  assign o_done    = r_act && (r_cnt == LAST);
  assign o_ready   = !r_act || o_done;
  assign w_accept  = i_start && o_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_act  <= 1'b0;
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_rs   <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_act  <= 1'b1;
      r_cnt  <= '0;
      r_rs   <= i_rs_data[8];
      r_data <= i_rs_data[7:0];
      r_en   <= (SETUP_CYC == 0);
    end else if (o_done) begin
      r_act <= 1'b0;
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (r_act) begin
      r_cnt <= w_cnt_inc;
      // EN is registered, so decide it from the count the next cycle will hold.
      r_en  <= (w_cnt_inc >= EN_LO) && (w_cnt_inc < EN_HI);
    end
  end

  assign lcd.LCD_EN   = r_en;
  assign lcd.LCD_RS   = r_rs;
  assign lcd.LCD_DATA = r_data;
  assign lcd.LCD_RW   = 1'b0;

endmodule

// File: rtl/lcd_hex_panel.sv
// lcd_hex_panel: renders ROWS x FIELDS bytes as "HH " fields on a ROWS x COLS
// HD44780 display.
//  iCLK, iRST   clock, synchronous active-high reset
//  iDATA        byte r*FIELDS+f at [8*(r*FIELDS+f)+:8]
//  iON_CHANGE   0 = continuous refresh, 1 = refresh on change / force only
//  iFORCE       pulse: request one more frame
//  oBUSY        init or frame in progress
//  oFRAME       1-cycle pulse when a frame's last character completes
//  lcd          LCD pins (driven by lcd_bus_writer)
module lcd_hex_panel
  import lcd_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int FIELDS    = 5,
  parameter int INIT_DLY  = 750000,
  parameter int EN_CYC    = 16,
  parameter int SETUP_CYC = 4,
  parameter int WR_DLY    = 262142
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [ROWS*FIELDS*8-1:0] iDATA,
  input  logic                     iON_CHANGE,
  input  logic                     iFORCE,
  output logic                     oBUSY,
  output logic                     oFRAME,
  lcd_hex_panel_if.master lcd
);

  localparam int NB = ROWS * FIELDS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int FW = $clog2(FIELDS + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = (INIT_DLY > 1) ? $clog2(INIT_DLY) : 1;
  localparam logic [PW-1:0] PWR_LAST = PW'(INIT_DLY - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [FW-1:0] FLD_NUM  = FW'(FIELDS);

  panel_state_t    r_state, w_nxt;
  logic [PW-1:0]   r_pwr;
  logic [1:0]      r_init;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [FW-1:0]   r_fld;   // field of the current column; saturates at FIELDS
  logic [1:0]      r_ph;    // column position inside a field: hi, lo, space
  logic [NB*8-1:0] r_snap;
  logic            r_pend;

  logic            w_start, w_done, w_ready, w_fstart, w_frame;
  logic [8:0]      w_wr;
  logic            w_in_field;
  logic [FW-1:0]   w_fld_c;
  logic [BW-1:0]   w_bidx;
  logic [7:0]      w_byte;
  logic [3:0]      w_nib;
  logic [7:0]      w_char;

  // Character for the current column, taken from the frame snapshot.
  assign w_in_field = (r_fld < FLD_NUM);
  assign w_fld_c    = w_in_field ? r_fld : '0;
  assign w_bidx     = BW'(r_row * FIELDS + w_fld_c);
  assign w_byte     = r_snap[{w_bidx, 3'b000} +: 8];
  assign w_nib      = (r_ph == 2'd0) ? w_byte[7:4] : w_byte[3:0];
  assign w_char     = (w_in_field && r_ph != 2'd2) ? hex2ascii(w_nib) : CHAR_SPACE;

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_wr     = '0;
    w_fstart = 1'b0;
    w_frame  = 1'b0;
    case (r_state)
      ST_PWR_WAIT: if (r_pwr == PWR_LAST) w_nxt = ST_INIT;
      ST_INIT: begin
        w_start = 1'b1;
        w_wr    = {1'b0, init_cmd(r_init)};
        if (w_ready && r_init == 2'd3) begin
          w_nxt    = ST_ROW_ADDR;
          w_fstart = 1'b1;
        end
      end
      ST_ROW_ADDR: begin
        w_start = 1'b1;
        w_wr    = {1'b0, CMD_DDRAM | row_base(2'(r_row))};
        if (w_ready) w_nxt = ST_CHARS;
      end
      ST_CHARS: begin
        w_start = 1'b1;
        w_wr    = {1'b1, w_char};
        if (w_ready && r_col == COL_LAST)
          w_nxt = (r_row == ROW_LAST) ? ST_FRAME_END : ST_ROW_ADDR;
      end
      ST_FRAME_END: begin
        // Last character is still on the bus; finish when its write completes.
        if (w_done) begin
          w_frame = 1'b1;
          w_nxt   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!iON_CHANGE || iDATA != r_snap || r_pend) begin
          w_nxt    = ST_ROW_ADDR;
          w_fstart = 1'b1;
        end
      end
      default: w_nxt = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_PWR_WAIT;
      r_pwr   <= '0;
      r_init  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_fld   <= '0;
      r_ph    <= '0;
      r_snap  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_PWR_WAIT)
        r_pwr <= (r_pwr == PWR_LAST) ? '0 : r_pwr + 1'b1;
      if (r_state == ST_INIT && w_ready)
        r_init <= (r_init == 2'd3) ? 2'd0 : r_init + 1'b1;
      if (w_fstart) begin
        r_snap <= iDATA;
        r_row  <= '0;
        r_col  <= '0;
        r_fld  <= '0;
        r_ph   <= '0;
      end else if (r_state == ST_CHARS && w_ready) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_fld <= '0;
          r_ph  <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
          r_ph  <= (r_ph == 2'd2) ? 2'd0 : r_ph + 1'b1;
          if (r_ph == 2'd2 && w_in_field) r_fld <= r_fld + 1'b1;
        end
      end
      // Force requests only count once the display is initialised; the
      // frame that starts consumes them, so repeated pulses coalesce.
      if (w_fstart)
        r_pend <= 1'b0;
      else if (iFORCE && r_state != ST_PWR_WAIT && r_state != ST_INIT)
        r_pend <= 1'b1;
    end
  end

  assign oBUSY  = (r_state != ST_IDLE);
  assign oFRAME = w_frame;

  lcd_bus_writer #(
    .EN_CYC   (EN_CYC),
    .SETUP_CYC(SETUP_CYC),
    .WR_DLY   (WR_DLY)
  ) u_wr (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .i_start  (w_start),
    .i_rs_data(w_wr),
    .o_done   (w_done),
    .o_ready  (w_ready),
    .lcd      (lcd)
  );

endmodule

// File: tb/tb_lcd_hex_panel.sv
module tb_lcd_hex_panel;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 2 x 16, 5 fields.  DUT B: 4 x 20, 6 fields.
  logic         rst_a, onch_a, frc_a, busy_a, frm_a;
  logic [79:0]  dat_a;
  logic         rst_b, onch_b, frc_b, busy_b, frm_b;
  logic [191:0] dat_b;
  logic [7:0]   da[24];
  logic [7:0]   db[24];

  lcd_hex_panel_if ifa();
  lcd_hex_panel_if ifb();

  lcd_hex_panel #(.ROWS(2), .COLS(16), .FIELDS(5), .INIT_DLY(20),
                  .EN_CYC(2), .SETUP_CYC(1), .WR_DLY(5)) dut_a (
    .iCLK(clk), .iRST(rst_a), .iDATA(dat_a), .iON_CHANGE(onch_a), .iFORCE(frc_a),
    .oBUSY(busy_a), .oFRAME(frm_a), .lcd(ifa));

  lcd_hex_panel #(.ROWS(4), .COLS(20), .FIELDS(6), .INIT_DLY(20),
                  .EN_CYC(2), .SETUP_CYC(1), .WR_DLY(5)) dut_b (
    .iCLK(clk), .iRST(rst_b), .iDATA(dat_b), .iON_CHANGE(onch_b), .iFORCE(frc_b),
    .oBUSY(busy_b), .oFRAME(frm_b), .lcd(ifb));

  always_comb begin
    dat_a = '0;
    for (int i = 0; i < 10; i++) dat_a[8*i +: 8] = da[i];
  end
  always_comb begin
    dat_b = '0;
    for (int i = 0; i < 24; i++) dat_b[8*i +: 8] = db[i];
  end

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + {4'd0, n};
    else           return 8'd65 + {4'd0, n} - 8'd10;
  endfunction

  task automatic put(input int which, input logic [8:0] w);
    if (which == 0) exp_a.push_back(w);
    else            exp_b.push_back(w);
  endtask

  task automatic push_init(input int which);
    put(which, 9'h038);
    put(which, 9'h00C);
    put(which, 9'h001);
    put(which, 9'h006);
  endtask

  task automatic push_frame(input int which, input int rows, input int cols,
                            input int fields, input logic [7:0] d[24]);
    logic [8:0] w;
    logic [7:0] b, base;
    for (int r = 0; r < rows; r++) begin
      case (r)
        0:       base = 8'h00;
        1:       base = 8'h40;
        2:       base = 8'h14;
        default: base = 8'h54;
      endcase
      put(which, {1'b0, 8'h80 | base});
      for (int c = 0; c < cols; c++) begin
        if (c < 3*fields) begin
          b = d[r*fields + c/3];
          case (c % 3)
            0:       w = {1'b1, asc(b[7:4])};
            1:       w = {1'b1, asc(b[3:0])};
            default: w = 9'h120;
          endcase
        end else begin
          w = 9'h120;
        end
        put(which, w);
      end
    end
  endtask

  // Bus monitors: one write logged per LCD_EN falling edge.
  logic pen_a = 1'b0, pen_b = 1'b0;
  int   falls_a = 0, frames_b = 0;
  int   ft[8];

  always @(negedge clk) begin
    pen_a <= ifa.LCD_EN;
    if (pen_a && !ifa.LCD_EN && !rst_a) begin
      falls_a <= falls_a + 1;
      if (falls_a < 8) ft[falls_a] <= cyc;
      chk("a_write_expected", (exp_a.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_a.size() > 0)
        chk("a_write", {23'd0, ifa.LCD_RS, ifa.LCD_DATA}, {23'd0, exp_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    pen_b <= ifb.LCD_EN;
    if (frm_b) frames_b <= frames_b + 1;
    if (pen_b && !ifb.LCD_EN && !rst_b) begin
      chk("b_write_expected", (exp_b.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_b.size() > 0)
        chk("b_write", {23'd0, ifb.LCD_RS, ifb.LCD_DATA}, {23'd0, exp_b.pop_front()});
    end
  end

  // Returns on the negedge where the n-th oFRAME pulse is seen.
  task automatic wait_frames_a(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (frm_a) seen++;
    end
    chk("a_frames_seen", seen, n);
  endtask

  task automatic pulse_force_a();
    frc_a = 1'b1;
    @(negedge clk);
    frc_a = 1'b0;
  endtask

  task automatic check_quiet_a(input string tag, input int ncyc);
    int f0;
    f0 = falls_a;
    repeat (ncyc) @(negedge clk);
    chk(tag, falls_a - f0, 0);
  endtask

  task automatic check_pwr_wait_a(input bool_force);
    int hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.LCD_EN) hi++;
      frc_a = (bool_force != 0) && (i == 5);
    end
    frc_a = 1'b0;
    chk("a_pwr_wait_no_en", hi, 0);
  endtask

  initial begin
    int seen;
    rst_a = 1'b1; onch_a = 1'b0; frc_a = 1'b0;
    rst_b = 1'b1; onch_b = 1'b1; frc_b = 1'b0;
    for (int i = 0; i < 24; i++) begin
      da[i] = (i < 10) ? 8'(i) : 8'h00;
      db[i] = 8'(8'h10 + 8'(i * 7));
    end
    push_init(0);
    push_frame(0, 2, 16, 5, da);
    push_init(1);
    push_frame(1, 4, 20, 6, db);

    // T1: reset state, power-on wait, init spacing
    repeat (3) @(negedge clk);
    chk("rst_busy",  busy_a, 1);
    chk("rst_frame", frm_a, 0);
    chk("rst_en",    ifa.LCD_EN, 0);
    chk("rst_rs",    ifa.LCD_RS, 0);
    chk("rst_data",  ifa.LCD_DATA, 0);
    chk("rst_rw",    ifa.LCD_RW, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_pwr_wait_a(1'b0);

    // T2: first frame with bytes 00..09
    wait_frames_a(1, 2000);
    for (int i = 1; i < 5; i++) chk("a_init_gap", ft[i] - ft[i-1], 9);

    // T3: A..F digits; data applied before the next frame latches
    da[0] = 8'hAF;
    da[1] = 8'h9A;
    push_frame(0, 2, 16, 5, da);
    wait_frames_a(1, 1000);

    // T5: change byte 0 while row 1 of the following frame is on the bus
    push_frame(0, 2, 16, 5, da);
    repeat (200) @(negedge clk);
    da[0] = 8'h55;
    wait_frames_a(1, 1000);
    push_frame(0, 2, 16, 5, da);
    wait_frames_a(1, 1000);

    // T4: change mode, stable data -> idle
    onch_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_idle_busy", busy_a, 0);
    check_quiet_a("a_idle_quiet", 500);
    da[3] = da[3] ^ 8'hFF;
    push_frame(0, 2, 16, 5, da);
    repeat (60) @(negedge clk);
    pulse_force_a();
    repeat (40) @(negedge clk);
    pulse_force_a();
    push_frame(0, 2, 16, 5, da);
    wait_frames_a(2, 2000);
    repeat (3) @(negedge clk);
    chk("a_idle_busy2", busy_a, 0);
    check_quiet_a("a_idle_quiet2", 300);

    // T6: reset while EN is high; a pending force must not survive it
    pulse_force_a();
    push_frame(0, 2, 16, 5, da);
    repeat (40) @(negedge clk);
    pulse_force_a();
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (ifa.LCD_EN) seen = 1;
    end
    chk("a_en_high_seen", seen, 1);
    rst_a = 1'b1;
    exp_a.delete();
    @(posedge clk);
    #1;
    chk("a_rst_en_drop", ifa.LCD_EN, 0);
    chk("a_rst_busy",    busy_a, 1);
    chk("a_rst_frame",   frm_a, 0);
    chk("a_rst_data",    ifa.LCD_DATA, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    push_init(0);
    push_frame(0, 2, 16, 5, da);
    check_pwr_wait_a(1'b1);
    wait_frames_a(1, 2000);
    repeat (3) @(negedge clk);
    chk("a_post_rst_busy", busy_a, 0);
    check_quiet_a("a_post_rst_quiet", 300);

    // T7 results (DUT B ran alongside in change mode)
    chk("b_frames",      frames_b, 1);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("b_idle_busy",   busy_b, 0);
    chk("a_queue_empty", exp_a.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
